// File: rtl/caster_pkg.sv
// Shared definitions for the EPD caster write-back path.
package caster_pkg;

    localparam int unsigned WORD_W        = 64;
    localparam int unsigned BURST_LEN_DEF = 16;
    localparam int unsigned LEN_W         = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StCmd  = 2'd1,
        StData = 2'd2
    } wb_state_e;

    // Burst length that never runs past the end of the frame.
    function automatic int unsigned burst_len(input int unsigned remain,
                                              input int unsigned max_len);
        return (remain < max_len) ? remain : max_len;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty/count status.
module wb_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_en;
    logic             pop_en;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    // A push at full is refused even if a pop frees a slot in the same cycle.
    assign push_en = push && !full;
    assign pop_en  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];
    assign count   = count_q;

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_en && !pop_en) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (pop_en && !push_en) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/vram_writeback.sv
// Buffers pipeline state words and writes them to VRAM as frame-bounded bursts.
module vram_writeback
    import caster_pkg::*;
#(
    parameter int unsigned ADDR_W      = 28,
    parameter int unsigned BASE_ADDR   = 0,
    parameter int unsigned FRAME_WORDS = 4800,
    parameter int unsigned BURST_LEN   = BURST_LEN_DEF,
    parameter int unsigned FIFO_DEPTH  = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                b_trigger,
    input  logic [WORD_W-1:0]   bo_pixel,
    input  logic                bo_valid,
    output logic                wr_cmd_valid,
    input  logic                wr_cmd_ready,
    output logic [ADDR_W-1:0]   wr_cmd_addr,
    output logic [LEN_W-1:0]    wr_cmd_len,
    output logic [WORD_W-1:0]   wr_data,
    output logic                wr_data_valid,
    input  logic                wr_data_ready,
    input  logic                err_clr,
    output logic                overflow,
    output logic                sync_err,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OC_W  = $clog2(FRAME_WORDS + 1);

    wb_state_e          state_q;
    logic [OC_W-1:0]    out_cnt_q;
    logic [LEN_W-1:0]   beat_cnt_q;
    logic               trig_q;

    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W-1:0]   fifo_cnt_next;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_en;
    logic               pop_en;
    logic               frame_start;
    logic               ovf_set;
    logic               sync_set;
    logic [LEN_W-1:0]   next_len;
    logic [31:0]        adv_sum;
    logic [OC_W-1:0]    out_cnt_adv;
    logic               last_beat;

    wb_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bo_valid),
        .wdata (bo_pixel),
        .pop   (pop_en),
        .rdata (wr_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign push_en       = bo_valid && !fifo_full;
    assign pop_en        = (state_q == StData) && wr_data_valid && wr_data_ready;
    assign fifo_cnt_next = fifo_cnt + CNT_W'(push_en) - CNT_W'(pop_en);

    assign next_len    = LEN_W'(burst_len(FRAME_WORDS - 32'(out_cnt_q), BURST_LEN));
    // Bursts end exactly on the frame boundary, so reaching it means wrap.
    assign adv_sum     = 32'(out_cnt_q) + 32'(wr_cmd_len);
    assign out_cnt_adv = (adv_sum >= FRAME_WORDS) ? '0 : OC_W'(adv_sum);
    assign last_beat   = pop_en && (beat_cnt_q == wr_cmd_len - LEN_W'(1));

    // Frame start only acts when nothing is queued or in flight.
    assign frame_start = b_trigger && !trig_q && (state_q == StIdle) && fifo_empty;
    assign ovf_set     = bo_valid && fifo_full;
    assign sync_set    = frame_start && (out_cnt_q != '0);

    // Sticky error flags and trigger edge history; a set beats a clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            sync_err <= 1'b0;
            trig_q   <= 1'b0;
        end else begin
            trig_q <= b_trigger;
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
            if (sync_set) begin
                sync_err <= 1'b1;
            end else if (err_clr) begin
                sync_err <= 1'b0;
            end
        end
    end

    // Burst FSM with frame position counter and registered port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            out_cnt_q     <= '0;
            beat_cnt_q    <= '0;
            wr_cmd_valid  <= 1'b0;
            wr_cmd_addr   <= ADDR_W'(BASE_ADDR);
            wr_cmd_len    <= '0;
            wr_data_valid <= 1'b0;
            busy          <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (frame_start && (sync_set || overflow)) begin
                        out_cnt_q <= '0;
                    end
                    if (32'(fifo_cnt) >= 32'(next_len)) begin
                        state_q      <= StCmd;
                        wr_cmd_valid <= 1'b1;
                        wr_cmd_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(out_cnt_q);
                        wr_cmd_len   <= next_len;
                        busy         <= 1'b1;
                    end else begin
                        busy <= (fifo_cnt_next != '0);
                    end
                end
                StCmd: begin
                    busy <= 1'b1;
                    if (wr_cmd_ready) begin
                        state_q       <= StData;
                        wr_cmd_valid  <= 1'b0;
                        beat_cnt_q    <= '0;
                        wr_data_valid <= (fifo_cnt_next != '0);
                    end
                end
                StData: begin
                    if (last_beat) begin
                        state_q       <= StIdle;
                        out_cnt_q     <= out_cnt_adv;
                        wr_data_valid <= 1'b0;
                        busy          <= (fifo_cnt_next != '0);
                    end else begin
                        if (pop_en) begin
                            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                        end
                        wr_data_valid <= (fifo_cnt_next != '0);
                        busy          <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // A burst only starts once all its words are queued, so data never stalls.
    assert property (@(posedge clk) disable iff (rst) (state_q == StData) |-> wr_data_valid);

endmodule

// File: tb/tb_vram_writeback.sv
// Self-checking bench for vram_writeback with a small frame (20 words).
module tb_vram_writeback;

    localparam int unsigned ADDR_W = 28;
    localparam int unsigned BASE   = 256;
    localparam int unsigned FRAME  = 20;
    localparam int unsigned BLEN   = 16;
    localparam int unsigned DEPTH  = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              b_trigger;
    logic [63:0]       bo_pixel;
    logic              bo_valid;
    logic              wr_cmd_valid;
    logic              wr_cmd_ready;
    logic [ADDR_W-1:0] wr_cmd_addr;
    logic [7:0]        wr_cmd_len;
    logic [63:0]       wr_data;
    logic              wr_data_valid;
    logic              wr_data_ready;
    logic              err_clr;
    logic              overflow;
    logic              sync_err;
    logic              busy;

    vram_writeback #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (BASE),
        .FRAME_WORDS (FRAME),
        .BURST_LEN   (BLEN),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .b_trigger     (b_trigger),
        .bo_pixel      (bo_pixel),
        .bo_valid      (bo_valid),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .err_clr       (err_clr),
        .overflow      (overflow),
        .sync_err      (sync_err),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: accepted words in order, frame position, sticky flags.
    logic [63:0]       exp_q[$];
    int                occ, pos, beats_left, n_cmds, n_beats;
    logic              ovf_m, sync_m, trig_prev, cmd_wait;
    logic [ADDR_W-1:0] held_addr, last_addr;
    logic [7:0]        held_len;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            occ = 0; pos = 0; beats_left = 0; n_cmds = 0; n_beats = 0;
            ovf_m = 1'b0; sync_m = 1'b0; trig_prev = 1'b0; cmd_wait = 1'b0;
        end else begin
            bit acc, pop, ovf_ev, sync_ev;
            int el;
            check("overflow", overflow, ovf_m);
            check("sync_err", sync_err, sync_m);
            check("data_valid", wr_data_valid, beats_left != 0);
            if (cmd_wait) begin
                check("cmd_hold_valid", wr_cmd_valid, 1);
                check("cmd_hold_addr", wr_cmd_addr, held_addr);
                check("cmd_hold_len", wr_cmd_len, held_len);
            end
            cmd_wait  = wr_cmd_valid && !wr_cmd_ready;
            held_addr = wr_cmd_addr;
            held_len  = wr_cmd_len;
            if (wr_cmd_valid && wr_cmd_ready) begin
                el = (FRAME - pos < BLEN) ? FRAME - pos : BLEN;
                check("cmd_addr", wr_cmd_addr, BASE + pos);
                check("cmd_len", wr_cmd_len, el);
                check("cmd_queued_words", occ >= el, 1);
                last_addr  = wr_cmd_addr;
                beats_left = el;
                pos        = (pos + el) % FRAME;
                n_cmds++;
            end
            pop = wr_data_valid && wr_data_ready;
            acc = bo_valid && (occ < DEPTH);
            ovf_ev  = bo_valid && !acc;
            sync_ev = 1'b0;
            if (b_trigger && !trig_prev && occ == 0) begin
                if (pos != 0) begin
                    sync_ev = 1'b1;
                    pos = 0;
                end
                if (ovf_m) pos = 0;
            end
            if (pop) begin
                check("beat_has_word", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("wr_data", wr_data, exp_q.pop_front());
                if (beats_left > 0) beats_left--;
                n_beats++;
            end
            if (acc) exp_q.push_back(bo_pixel);
            occ = occ + int'(acc) - int'(pop);
            ovf_m  = ovf_ev  ? 1'b1 : (err_clr ? 1'b0 : ovf_m);
            sync_m = sync_ev ? 1'b1 : (err_clr ? 1'b0 : sync_m);
            trig_prev = b_trigger;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; bo_valid = 1'b0; b_trigger = 1'b0; err_clr = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_words(input int n, input int base);
        for (int k = 0; k < n; k++) begin
            bo_valid = 1'b1;
            bo_pixel = 64'(base + k);
            step();
        end
        bo_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int c = 0;
        @(negedge clk);
        while (busy && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(name, busy, 0);
    endtask

    typedef struct {
        int   n_words;
        int   exp_cmds;
        int   exp_beats;
        logic exp_busy;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #2000000;
        $display("FAIL global_timeout: sim time %0t exceeded limit", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        vecs[0] = '{15, 0,  0, 1'b1};
        vecs[1] = '{16, 1, 16, 1'b0};
        vecs[2] = '{19, 1, 16, 1'b1};
        vecs[3] = '{20, 2, 20, 1'b0};
        vecs[4] = '{25, 2, 20, 1'b1};
        vecs[5] = '{36, 3, 36, 1'b0};
        vecs[6] = '{40, 4, 40, 1'b0};

        bo_pixel = '0; wr_cmd_ready = 1'b0; wr_data_ready = 1'b0;
        do_reset();
        @(negedge clk);
        check("rst_cmd_valid", wr_cmd_valid, 0);
        check("rst_data_valid", wr_data_valid, 0);
        check("rst_cmd_addr", wr_cmd_addr, BASE);
        check("rst_cmd_len", wr_cmd_len, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sync_err", sync_err, 0);
        check("rst_busy", busy, 0);

        // Burst count / length table, readies tied high.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            wr_cmd_ready = 1'b1; wr_data_ready = 1'b1;
            push_words(vecs[i].n_words, 1000 * (i + 1));
            repeat (60) step();
            @(negedge clk);
            check("vec_cmds", n_cmds, vecs[i].exp_cmds);
            check("vec_beats", n_beats, vecs[i].exp_beats);
            check("vec_busy", busy, vecs[i].exp_busy);
        end

        // Command latency, command backpressure, data backpressure.
        do_reset();
        wr_cmd_ready = 1'b0; wr_data_ready = 1'b1;
        push_words(16, 2000);
        @(negedge clk);
        check("cmd_latency_t1", wr_cmd_valid, 0);
        step();
        @(negedge clk);
        check("cmd_latency_t2", wr_cmd_valid, 1);
        repeat (10) step();
        wr_cmd_ready = 1'b1;
        @(negedge clk);
        check("data_before_hs", wr_data_valid, 0);
        step();
        wr_cmd_ready = 1'b0;
        @(negedge clk);
        check("data_after_hs", wr_data_valid, 1);
        for (int i = 0; i < 40; i++) begin
            wr_data_ready = i[0];
            step();
        end
        wr_data_ready = 1'b1;
        wait_idle("bp_idle", 100);
        check("bp_beats", n_beats, 16);

        // Overflow with the command port blocked.
        do_reset();
        wr_cmd_ready = 1'b0; wr_data_ready = 1'b1;
        push_words(64, 3000);
        @(negedge clk);
        check("ovf_at_64", overflow, 0);
        push_words(1, 3064);
        @(negedge clk);
        check("ovf_after_65", overflow, 1);
        bo_valid = 1'b1; bo_pixel = 64'd3065; err_clr = 1'b1;
        step();
        bo_valid = 1'b0;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", overflow, 0);
        push_words(4, 3066);
        @(negedge clk);
        check("ovf_reset_again", overflow, 1);
        wr_cmd_ready = 1'b1;
        repeat (150) step();
        @(negedge clk);
        check("ovf_beats", n_beats, 60);
        check("ovf_leftover_busy", busy, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        @(negedge clk);
        check("ovf_clr", overflow, 0);

        // Misaligned frame start, then an edge that must be ignored.
        do_reset();
        wr_cmd_ready = 1'b1; wr_data_ready = 1'b1;
        push_words(16, 5000);
        wait_idle("sync_drain", 100);
        b_trigger = 1'b1;
        step();
        b_trigger = 1'b0;
        @(negedge clk);
        check("sync_set", sync_err, 1);
        push_words(16, 5100);
        wait_idle("sync_next", 100);
        check("sync_next_addr", last_addr, BASE);
        check("sync_next_cmds", n_cmds, 2);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        push_words(3, 5200);
        b_trigger = 1'b1;
        step();
        b_trigger = 1'b0;
        step();
        @(negedge clk);
        check("sync_ignored_nonempty", sync_err, 0);

        // Reset in the middle of a burst.
        do_reset();
        wr_cmd_ready = 1'b1; wr_data_ready = 1'b1;
        push_words(16, 7000);
        c = 0;
        while (n_beats < 3 && c < 50) begin
            step();
            c++;
        end
        check("midrst_reached", n_beats >= 3, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_data_valid", wr_data_valid, 0);
        check("midrst_cmd_valid", wr_cmd_valid, 0);
        check("midrst_busy", busy, 0);
        push_words(16, 7100);
        wait_idle("midrst_idle", 100);
        check("midrst_beats", n_beats, 16);

        // Randomised traffic: moderate rate, then a saturating phase.
        do_reset();
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < 900; i++) begin
                bo_valid      = ($urandom_range(0, 99) < (ph == 0 ? 45 : 90));
                bo_pixel      = {$urandom, $urandom};
                wr_cmd_ready  = ($urandom_range(0, 99) < 70);
                wr_data_ready = ($urandom_range(0, 99) < 75);
                err_clr       = ($urandom_range(0, 99) < 3);
                if ($urandom_range(0, 99) < 5) b_trigger = ~b_trigger;
                step();
            end
        end
        bo_valid = 1'b0; err_clr = 1'b0; b_trigger = 1'b0;
        wr_cmd_ready = 1'b1; wr_data_ready = 1'b1;
        repeat (200) step();
        @(negedge clk);
        check("rand_busy", busy, occ != 0);
        check("rand_activity", n_cmds > 10, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
